// File: rtl/peripheral_uart_rx_ctrl_wb.sv
// UART receive-side control: RBR pop sequencing, FIFO clear, line-status clear,
// data-ready, trigger-level and character-timeout interrupts.
module peripheral_uart_rx_ctrl_wb #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_COUNTER_W = 5
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      rbr_rd,
  input  logic                      lsr_rd,
  input  logic                      fcr_wr,
  input  logic                      fcr_rx_clr,
  input  logic                      fifo_en,
  input  logic [1:0]                trig_sel,
  input  logic                      char_tick,
  input  logic                      rx_push,
  input  logic [FIFO_COUNTER_W-1:0] fifo_count,
  output logic                      fifo_pop,
  output logic                      fifo_reset,
  output logic                      reset_status,
  output logic                      data_ready,
  output logic                      rda_int,
  output logic                      tout_int,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  localparam logic [FIFO_COUNTER_W-1:0] FULL_CNT = FIFO_COUNTER_W'(FIFO_DEPTH);

  state_t     state;
  logic       fifo_en_p0;
  logic [2:0] tout_cnt_p0;
  logic [2:0] tout_cnt_nxt;
  logic       clr_req;
  logic       cnt_nz;

  // Trigger level in characters; a disabled FIFO behaves as a one-character holding register.
  function automatic logic [FIFO_COUNTER_W-1:0] trig_level(input logic [1:0] sel,
                                                             input logic       en);
    logic [FIFO_COUNTER_W-1:0] lvl;
    lvl = FIFO_COUNTER_W'(1);
    if (en) begin
      case (sel)
        2'b00:   lvl = FIFO_COUNTER_W'(1);
        2'b01:   lvl = FIFO_COUNTER_W'(4);
        2'b10:   lvl = FIFO_COUNTER_W'(8);
        default: lvl = FIFO_COUNTER_W'(14);
      endcase
    end
    return lvl;
  endfunction

  function automatic logic [2:0] sat_inc4(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd4 : v + 3'd1;
  endfunction

  assign clr_req = (fcr_wr & fcr_rx_clr) | (fifo_en != fifo_en_p0);
  assign cnt_nz  = (fifo_count != '0);

  always_comb begin
    tout_cnt_nxt = tout_cnt_p0;
    if (rx_push || fifo_pop || fifo_reset || !cnt_nz)
      tout_cnt_nxt = 3'd0;
    else if (char_tick)
      tout_cnt_nxt = sat_inc4(tout_cnt_p0);
  end

  // Stage p0: every output is registered from the current-cycle inputs.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      fifo_en_p0   <= 1'b0;
      tout_cnt_p0  <= 3'd0;
      fifo_pop     <= 1'b0;
      fifo_reset   <= 1'b0;
      reset_status <= 1'b0;
      data_ready   <= 1'b0;
      rda_int      <= 1'b0;
      tout_int     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fifo_en_p0   <= fifo_en;
      fifo_reset   <= clr_req;
      reset_status <= clr_req | lsr_rd;
      data_ready   <= cnt_nz;
      rda_int      <= (fifo_count >= trig_level(trig_sel, fifo_en)) || (fifo_count >= FULL_CNT);
      tout_cnt_p0  <= tout_cnt_nxt;
      tout_int     <= (tout_cnt_nxt == 3'd4) && cnt_nz && fifo_en;

      // A clear being issued (now or next cycle) wins over any pop.
      if (clr_req || fifo_reset) begin
        state    <= IDLE;
        fifo_pop <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
            if (rbr_rd && cnt_nz) begin
              state    <= POP;
              fifo_pop <= 1'b1;
              busy     <= 1'b1;
            end
          end
          POP: begin
            state    <= SETTLE;
            fifo_pop <= 1'b0;
            busy     <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_uart_rx_ctrl_wb.sv
// Directed bench for peripheral_uart_rx_ctrl_wb with hand-computed expectations.
module tb_peripheral_uart_rx_ctrl_wb;

  logic       clk = 1'b0;
  logic       wb_rst_i, rbr_rd, lsr_rd, fcr_wr, fcr_rx_clr, fifo_en;
  logic [1:0] trig_sel;
  logic       char_tick, rx_push;
  logic [4:0] fifo_count;
  logic       fifo_pop, fifo_reset, reset_status, data_ready, rda_int, tout_int, busy;

  int vectors = 0;
  int errs    = 0;

  peripheral_uart_rx_ctrl_wb #(.FIFO_DEPTH(16), .FIFO_COUNTER_W(5)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd),
    .fcr_wr(fcr_wr), .fcr_rx_clr(fcr_rx_clr), .fifo_en(fifo_en),
    .trig_sel(trig_sel), .char_tick(char_tick), .rx_push(rx_push),
    .fifo_count(fifo_count), .fifo_pop(fifo_pop), .fifo_reset(fifo_reset),
    .reset_status(reset_status), .data_ready(data_ready), .rda_int(rda_int),
    .tout_int(tout_int), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; rbr_rd = 1'b0; lsr_rd = 1'b0; fcr_wr = 1'b0; fcr_rx_clr = 1'b0;
    fifo_en = 1'b0; trig_sel = 2'b00; char_tick = 1'b0; rx_push = 1'b0; fifo_count = 5'd1;
    step(); step();
    chk("rst_pop", fifo_pop, 1'b0);     chk("rst_frst", fifo_reset, 1'b0);
    chk("rst_rst", reset_status, 1'b0); chk("rst_dr", data_ready, 1'b0);
    chk("rst_rda", rda_int, 1'b0);      chk("rst_tout", tout_int, 1'b0);
    chk("rst_busy", busy, 1'b0);
    wb_rst_i = 1'b0;

    // FIFO disabled: trigger level is 1.
    step();
    chk("dis_rda1", rda_int, 1'b1); chk("dis_dr", data_ready, 1'b1);
    chk("dis_nofrst", fifo_reset, 1'b0);

    // Enable toggle -> single clear pulse.
    fifo_en = 1'b1; step();
    chk("en_frst", fifo_reset, 1'b1); chk("en_rst", reset_status, 1'b1);
    step();
    chk("en_frst_end", fifo_reset, 1'b0); chk("en_rst_end", reset_status, 1'b0);

    // Trigger level thresholds.
    trig_sel = 2'b10; fifo_count = 5'd7; step(); chk("trig8_c7", rda_int, 1'b0);
    fifo_count = 5'd8; step();                    chk("trig8_c8", rda_int, 1'b1);
    trig_sel = 2'b11; fifo_count = 5'd13; step(); chk("trig14_c13", rda_int, 1'b0);
    fifo_count = 5'd16; step();                   chk("trig14_full", rda_int, 1'b1);

    // Line status read.
    lsr_rd = 1'b1; step(); lsr_rd = 1'b0;
    chk("lsr_rst", reset_status, 1'b1); chk("lsr_nofrst", fifo_reset, 1'b0);
    step(); chk("lsr_rst_end", reset_status, 1'b0);

    // Pop sequence, second read while busy ignored.
    fifo_count = 5'd3; rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("pop1", fifo_pop, 1'b1); chk("busy1", busy, 1'b1);
    rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("settle_pop", fifo_pop, 1'b0); chk("busy2", busy, 1'b1);
    rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("idle_pop", fifo_pop, 1'b0); chk("busy3", busy, 1'b0);
    step(); chk("no_queued_pop", fifo_pop, 1'b0);

    // Read with empty FIFO.
    fifo_count = 5'd0; rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("empty_pop", fifo_pop, 1'b0); chk("empty_busy", busy, 1'b0);
    chk("empty_dr", data_ready, 1'b0);

    // Character timeout.
    fifo_count = 5'd2; step();
    for (int i = 1; i <= 4; i++) begin
      char_tick = 1'b1; step(); char_tick = 1'b0;
      chk("tout_tick", tout_int, (i == 4));
    end
    rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("tout_pop", fifo_pop, 1'b1); chk("tout_hold", tout_int, 1'b1);
    step(); chk("tout_drop", tout_int, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      char_tick = 1'b1; step(); char_tick = 1'b0;
      chk("tout_restart", tout_int, (i == 4));
    end
    char_tick = 1'b1; rx_push = 1'b1; step(); char_tick = 1'b0; rx_push = 1'b0;
    chk("tout_push_prio", tout_int, 1'b0);

    // Clear and read in the same cycle: clear wins.
    fifo_count = 5'd3; rbr_rd = 1'b1; fcr_wr = 1'b1; fcr_rx_clr = 1'b1; step();
    rbr_rd = 1'b0; fcr_wr = 1'b0; fcr_rx_clr = 1'b0;
    chk("clr_frst", fifo_reset, 1'b1); chk("clr_rst", reset_status, 1'b1);
    chk("clr_nopop", fifo_pop, 1'b0);  chk("clr_nobusy", busy, 1'b0);
    step(); chk("clr_frst_end", fifo_reset, 1'b0); chk("clr_nopop2", fifo_pop, 1'b0);

    // Reset during POP aborts the sequence.
    rbr_rd = 1'b1; step(); rbr_rd = 1'b0;
    chk("pre_rst_pop", fifo_pop, 1'b1);
    wb_rst_i = 1'b1; fifo_en = 1'b0; step();
    chk("abort_pop", fifo_pop, 1'b0); chk("abort_busy", busy, 1'b0);
    chk("abort_dr", data_ready, 1'b0); chk("abort_rda", rda_int, 1'b0);
    chk("abort_tout", tout_int, 1'b0); chk("abort_frst", fifo_reset, 1'b0);
    chk("abort_rst", reset_status, 1'b0);
    wb_rst_i = 1'b0; step();
    chk("post_rst_pop", fifo_pop, 1'b0); chk("post_rst_busy", busy, 1'b0);
    step(); chk("post_rst_pop2", fifo_pop, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
